// File: rtl/pcss_link_tx_arb.sv
// rtl/pcss_link_tx_arb.sv - round-robin egress scheduler with four-phase flit serializer and parity retry
module pcss_link_tx_arb #(
  parameter int NREQ           = 4,
  parameter int PKT_W          = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int MAX_RETRY      = 3,
  localparam int GW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*PKT_W-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out,
  output logic                      send_data_valid,
  output logic                      send_data_par,
  input  logic                      send_data_ready,
  input  logic                      send_data_err,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      pkt_drop
);
  localparam int NFLIT = PKT_W / CHIPDATA_WIDTH;
  localparam int FW    = (NFLIT > 1) ? $clog2(NFLIT) : 1;
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [PKT_W-1:0]    shreg_q, shreg_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [FW-1:0]       flit_q, flit_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                rflag_q, rflag_d;
  logic                valid_q, valid_d;
  logic                par_q, par_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;

  logic                found;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       next_rr;
  int unsigned         cand;

  // Cyclic first-valid search starting at the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_q) + k) % NREQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = GW'(cand);
      end
    end
  end

  assign next_rr = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    flit_d    = flit_q;
    retry_d   = retry_q;
    rflag_d   = rflag_q;
    valid_d   = valid_q;
    par_d     = par_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          req_ready[pick] = 1'b1;
          shreg_d = req_data[int'(pick)*PKT_W +: PKT_W];
          grant_d = pick;
          flit_d  = '0;
          retry_d = '0;
          rflag_d = 1'b0;
          valid_d = 1'b1;
          par_d   = ^shreg_d[PKT_W-1 -: CHIPDATA_WIDTH];
          state_d = SEND;
        end
      end
      SEND: begin
        if (send_data_ready) begin
          valid_d = 1'b0;
          rflag_d = send_data_err;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!send_data_ready) begin
          if (rflag_q) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              valid_d = 1'b1;
              state_d = SEND;
            end else begin
              drop_d  = 1'b1;
              rr_d    = next_rr;
              state_d = IDLE;
            end
          end else if (flit_q == FW'(NFLIT - 1)) begin
            done_d  = 1'b1;
            rr_d    = next_rr;
            state_d = IDLE;
          end else begin
            // Shift lands on the same edge valid rises, so data never moves mid-window.
            flit_d  = flit_q + 1'b1;
            shreg_d = shreg_q << CHIPDATA_WIDTH;
            retry_d = '0;
            valid_d = 1'b1;
            par_d   = ^shreg_d[PKT_W-1 -: CHIPDATA_WIDTH];
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      flit_q  <= '0;
      retry_q <= '0;
      rflag_q <= 1'b0;
      valid_q <= 1'b0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      flit_q  <= flit_d;
      retry_q <= retry_d;
      rflag_q <= rflag_d;
      valid_q <= valid_d;
      par_q   <= par_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign send_data_out   = shreg_q[PKT_W-1 -: CHIPDATA_WIDTH];
  assign send_data_valid = valid_q;
  assign send_data_par   = par_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q != IDLE);
  assign pkt_done        = done_q;
  assign pkt_drop        = drop_q;
endmodule

// File: tb/tb_pcss_link_tx_arb.sv
// tb/tb_pcss_link_tx_arb.sv - vector table, directed corner sequences and randomized traffic against a scoreboard model
module tb_pcss_link_tx_arb;
  localparam int NREQ = 4, PKT_W = 64, CW = 16, MAX_RETRY = 3, NFLIT = PKT_W / CW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*PKT_W-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic [CW-1:0]         send_data_out;
  logic                  send_data_valid, send_data_par;
  logic                  send_data_ready = 1'b0;
  logic                  send_data_err = 1'b0;
  logic [1:0]            grant_id;
  logic                  busy, pkt_done, pkt_drop;

  always #5 clk = ~clk;

  pcss_link_tx_arb #(.NREQ(NREQ), .PKT_W(PKT_W), .CHIPDATA_WIDTH(CW), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .send_data_out(send_data_out), .send_data_valid(send_data_valid), .send_data_par(send_data_par),
    .send_data_ready(send_data_ready), .send_data_err(send_data_err), .grant_id(grant_id),
    .busy(busy), .pkt_done(pkt_done), .pkt_drop(pkt_drop));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] flit_of(input logic [PKT_W-1:0] p, input int k);
    return CW'(p >> (PKT_W - CW * (k + 1)));
  endfunction

  typedef logic [PKT_W-1:0] pq_t[$];
  pq_t rq [NREQ];
  logic [NREQ-1:0] xfer_mask = '0;

  // Scoreboard state: what the link should be doing, derived from the protocol rules.
  bit             m_active = 0;
  int             m_grant = 0, m_k = 0, m_tries = 0, m_acks = 0, m_end = 0, m_rr = 0, w_exp = 0;
  logic [PKT_W-1:0] m_pkt = '0;
  int             grants = 0, end_count = 0, ready_cycles = 0;
  int             last_end = 0, last_acks = 0;
  logic [CW-1:0]  last_f0 = '0, prev_data = '0;
  logic           last_p0 = 1'b0;
  bit             just_acc = 0, prev_valid = 0, prev_pulse = 0, rx_e = 0;
  int             grant_log[$];

  int rx_delay = 0, rx_hold = 0, rx_cnt = 0, err_flit = -1, err_left = 0;
  bit rand_mode = 0;

  function automatic int winner();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return 0;
  endfunction

  task automatic finish_pkt(input int kind);
    m_end     = kind;
    m_active  = 0;
    m_rr      = (m_grant + 1) % NREQ;
    last_acks = m_acks;
  endtask

  task automatic model_ack(input bit e);
    logic [CW-1:0] f;
    chk("ack_inside_packet", m_active, 1);
    if (!m_active) return;
    f = flit_of(m_pkt, m_k);
    chk("flit_data", send_data_out, f);
    chk("flit_par", send_data_par, ^f);
    chk("grant_id", grant_id, m_grant);
    if (m_acks == 0) begin
      last_f0 = send_data_out;
      last_p0 = send_data_par;
    end
    m_acks++;
    if (e) begin
      m_tries++;
      if (m_tries > MAX_RETRY) finish_pkt(2);
    end else if (m_k == NFLIT - 1) begin
      finish_pkt(1);
    end else begin
      m_k++;
      m_tries = 0;
    end
  endtask

  // Monitor, scoreboard and four-phase receiver share one process so their order is fixed.
  always @(negedge clk) begin
    xfer_mask = '0;
    if (rst) begin
      send_data_ready = 1'b0;
      send_data_err   = 1'b0;
      rx_cnt = 0; m_active = 0; m_end = 0; m_rr = 0;
      just_acc = 0; prev_valid = 0; prev_pulse = 0;
    end else begin
      if (just_acc) begin
        chk("accept_latency_valid", send_data_valid, 1);
        chk("accept_latency_busy", busy, 1);
        just_acc = 0;
      end
      if (send_data_ready) chk("valid_low_while_ready_high", send_data_valid, 0);
      if (busy) chk("no_req_ready_while_busy", req_ready, 0);
      if (|req_ready) ready_cycles++;
      if (send_data_valid && prev_valid) chk("flit_stable_in_window", send_data_out, prev_data);
      prev_valid = send_data_valid;
      prev_data  = send_data_out;
      if (pkt_done || pkt_drop) begin
        chk("end_pulse_kind", {pkt_drop, pkt_done}, m_end);
        chk("end_pulse_single_cycle", prev_pulse, 0);
        if (m_end != 0) begin
          last_end = m_end;
          end_count++;
        end
        m_end = 0;
      end
      prev_pulse = pkt_done || pkt_drop;
      if (|(req_valid & req_ready)) begin
        w_exp = winner();
        chk("grant_onehot_rr", req_ready, NREQ'(1) << w_exp);
        chk("accept_only_when_idle", m_active || (m_end != 0), 0);
        m_active = 1; m_grant = w_exp; m_k = 0; m_tries = 0; m_acks = 0;
        m_pkt = req_data[w_exp*PKT_W +: PKT_W];
        grants++;
        grant_log.push_back(w_exp);
        xfer_mask = req_valid & req_ready;
        just_acc = 1;
      end
      if (send_data_valid && !send_data_ready) begin
        if (rx_cnt >= rx_delay) begin
          if (rand_mode) rx_e = ($urandom_range(0, 5) == 0);
          else begin
            rx_e = (m_k == err_flit) && (err_left > 0);
            if (rx_e) err_left--;
          end
          send_data_ready = 1'b1;
          send_data_err   = rx_e;
          rx_cnt = 0;
          model_ack(rx_e);
          if (rand_mode) begin
            rx_delay = $urandom_range(0, 3);
            rx_hold  = $urandom_range(0, 3);
          end
        end else begin
          rx_cnt++;
          if (rand_mode) send_data_err = 1'($urandom_range(0, 1));
        end
      end else if (send_data_ready && !send_data_valid) begin
        if (rx_cnt >= rx_hold) begin
          send_data_ready = 1'b0;
          rx_cnt = 0;
        end else rx_cnt++;
        if (rand_mode) send_data_err = 1'($urandom_range(0, 1));
      end
    end
  end

  // Requesters present the head of their queue; a granted head is retired after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i] = (rq[i].size() > 0);
      req_data[i*PKT_W +: PKT_W] = (rq[i].size() > 0) ? rq[i][0] : '0;
    end
  end

  task automatic wait_ends(input int n);
    int start, t;
    start = end_count;
    t = 0;
    while (end_count < start + n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("packet_end_within_budget", end_count - start, n);
  endtask

  typedef struct {
    int          req;
    logic [63:0] pkt;
    int          err_flit;
    int          err_n;
    int          exp_acks;
    int          exp_end;
    logic [15:0] exp_f0;
    logic        exp_p0;
  } vec_t;

  vec_t tv[5];
  int   exp_order[5];
  int   gl0, t, e0;
  bit   pending;

  initial begin
    tv[0] = '{0, 64'h0123_4567_89AB_CDEF, -1, 0, 4, 1, 16'h0123, 1'b0};
    tv[1] = '{1, 64'hFFFE_0001_1234_8000,  2, 1, 5, 1, 16'hFFFE, 1'b1};
    tv[2] = '{2, 64'hA5A5_5A5A_0F0F_F0F0,  1, 99, 5, 2, 16'hA5A5, 1'b0};
    tv[3] = '{3, 64'h8000_0000_0000_0001,  0, 3, 7, 1, 16'h8000, 1'b1};
    tv[4] = '{0, 64'h7FFF_1111_2222_3333,  3, 4, 7, 2, 16'h7FFF, 1'b1};
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_send_data_out", send_data_out, 0);
    chk("rst_send_data_valid", send_data_valid, 0);
    chk("rst_send_data_par", send_data_par, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_drop", pkt_drop, 0);

    // All requesters valid continuously from reset.
    for (int i = 0; i < NREQ; i++) rq[i].push_back({32'h1000_0000 * (i + 1), 32'hCAFE_0000 + i});
    rq[0].push_back(64'hDEAD_BEEF_0BAD_F00D);
    repeat (2) @(posedge clk);
    #2;
    chk("req_ready_low_in_reset", req_ready, 0);
    rst = 1'b0;
    wait_ends(5);
    chk("rr_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant_%0d", i), grant_log[i], exp_order[i]);

    for (int i = 0; i < 5; i++) begin
      err_flit = tv[i].err_flit;
      err_left = tv[i].err_n;
      gl0 = grant_log.size();
      rq[tv[i].req].push_back(tv[i].pkt);
      wait_ends(1);
      chk($sformatf("vec%0d_grant", i), grant_log[gl0], tv[i].req);
      chk($sformatf("vec%0d_outcome", i), last_end, tv[i].exp_end);
      chk($sformatf("vec%0d_valid_pulses", i), last_acks, tv[i].exp_acks);
      chk($sformatf("vec%0d_flit0", i), last_f0, tv[i].exp_f0);
      chk($sformatf("vec%0d_par0", i), last_p0, tv[i].exp_p0);
      repeat (2) @(posedge clk);
    end
    err_flit = -1;
    err_left = 0;

    // Receiver holds ready high for ten cycles after each acknowledge.
    rx_hold = 10;
    rq[1].push_back(64'h1357_9BDF_2468_ACE0);
    wait_ends(1);
    chk("hold_outcome", last_end, 1);
    chk("hold_valid_pulses", last_acks, 4);
    rx_hold = 0;

    // Reset during SEND of flit 2, with rr_ptr left pointing past requester 0.
    rq[0].push_back(64'h0F1E_2D3C_4B5A_6978);
    wait_ends(1);
    rx_delay = 6;
    rq[2].push_back(64'hFEDC_BA98_7654_3210);
    t = 0;
    while (!(m_active && m_k == 2 && send_data_valid && !send_data_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reached_send_flit2", m_k, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", send_data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_no_done", pkt_done, 0);
    chk("mid_rst_no_drop", pkt_drop, 0);
    rst = 1'b0;
    rx_delay = 0;
    e0 = end_count;
    repeat (6) @(posedge clk);
    chk("no_end_after_reset", end_count, e0);
    gl0 = grant_log.size();
    rq[1].push_back(64'hAAAA_5555_AAAA_5555);
    rq[0].push_back(64'h0001_0002_0003_0004);
    wait_ends(2);
    chk("post_rst_first_grant", grant_log[gl0], 0);
    chk("post_rst_second_grant", grant_log[gl0 + 1], 1);

    // Randomized traffic, receiver timing and error injection.
    rand_mode = 1;
    for (int n = 0; n < 120; n++) begin
      rq[$urandom_range(0, NREQ - 1)].push_back({$urandom, $urandom});
      repeat ($urandom_range(0, 25)) @(posedge clk);
    end
    t = 0;
    pending = 1;
    while (pending && t < 30000) begin
      @(posedge clk);
      t++;
      pending = m_active || (m_end != 0) || busy;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) pending = 1;
    end
    chk("random_drain_within_budget", pending, 0);
    rand_mode = 0;
    repeat (5) @(posedge clk);
    chk("req_ready_one_cycle_per_grant", ready_cycles, grants);
    chk("every_grant_ends_except_reset", end_count, grants - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
